// File: rtl/muldiv.sv
// Multi-cycle multiply/divide unit feeding the HI/LO register: a registered
// product for MULT/MULTU, a 32-step restoring divider for DIV/DIVU, and a
// direct path for MTHI/MTLO.
module muldiv #(
   parameter int MUL_LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   input  logic [63:0] hilo_rdata,
   output logic        busy,
   output logic        hilo_we,
   output logic [63:0] hilo_wdata
);

   typedef enum logic [1:0] {Idle, Mul, Div, Wr} state_t;

   localparam logic [2:0] OpMult  = 3'd1;
   localparam logic [2:0] OpMultu = 3'd2;
   localparam logic [2:0] OpDiv   = 3'd3;
   localparam logic [2:0] OpDivu  = 3'd4;
   localparam logic [2:0] OpMthi  = 3'd5;
   localparam logic [2:0] OpMtlo  = 3'd6;

   localparam logic [4:0] MulLast = (MUL_LATENCY > 1) ? 5'(MUL_LATENCY - 2) : 5'd0;
   localparam logic [4:0] DivLast = 5'd31;

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic [63:0] res_q;
   logic [63:0] hiloWdata_q;
   logic [31:0] rem_q, quo_q, divisor_q;
   logic        negQuo_q, negRem_q, divZero_q;

   logic        accept, isSigned, isMul, isMt;
   logic        aNeg, bNeg;
   logic [31:0] aMag, bMag;
   logic [63:0] mulA, mulB, product, immRes;
   logic [32:0] shifted;
   logic        geq;
   logic [31:0] rem_d, quo_d;
   logic [63:0] divRes;

   // Operand decode, magnitudes for the divider and the product, all from C0 inputs.
   always_comb begin
      accept   = op_valid && !flush && (state_q == Idle) && (op != 3'd0) && (op != 3'd7);
      isSigned = (op == OpMult) || (op == OpDiv);
      isMul    = (op == OpMult) || (op == OpMultu);
      isMt     = (op == OpMthi) || (op == OpMtlo);
      aNeg     = isSigned && src_a[31];
      bNeg     = isSigned && src_b[31];
      aMag     = aNeg ? -src_a : src_a;
      bMag     = bNeg ? -src_b : src_b;
      mulA     = {{32{aNeg}}, src_a};
      mulB     = {{32{bNeg}}, src_b};
      product  = mulA * mulB;
      if (op == OpMthi)
         immRes = {src_a, hilo_rdata[31:0]};
      else if (op == OpMtlo)
         immRes = {hilo_rdata[63:32], src_a};
      else
         immRes = product;
   end

   // One restoring-divide step; a zero divisor naturally yields rem=|a|, so only lo is forced.
   always_comb begin
      shifted = {rem_q, quo_q[31]};
      geq     = shifted >= {1'b0, divisor_q};
      rem_d   = geq ? 32'(shifted - {1'b0, divisor_q}) : shifted[31:0];
      quo_d   = {quo_q[30:0], geq};
      divRes  = {negRem_q ? -rem_d : rem_d,
                 divZero_q ? 32'hFFFF_FFFF : (negQuo_q ? -quo_d : quo_d)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= Idle;
         cnt_q       <= 5'd0;
         res_q       <= 64'd0;
         hiloWdata_q <= 64'd0;
         rem_q       <= 32'd0;
         quo_q       <= 32'd0;
         divisor_q   <= 32'd0;
         negQuo_q    <= 1'b0;
         negRem_q    <= 1'b0;
         divZero_q   <= 1'b0;
      end else if (flush) begin
         state_q <= Idle;
         cnt_q   <= 5'd0;
      end else begin
         case (state_q)
            Idle: begin
               if (accept) begin
                  cnt_q <= 5'd0;
                  if (isMt || (isMul && MUL_LATENCY == 1)) begin
                     state_q     <= Wr;
                     hiloWdata_q <= immRes;
                  end else if (isMul) begin
                     state_q <= Mul;
                     res_q   <= product;
                  end else begin
                     state_q   <= Div;
                     rem_q     <= 32'd0;
                     quo_q     <= aMag;
                     divisor_q <= bMag;
                     negQuo_q  <= aNeg ^ bNeg;
                     negRem_q  <= aNeg;
                     divZero_q <= (src_b == 32'd0);
                  end
               end
            end
            Mul: begin
               if (cnt_q == MulLast) begin
                  state_q     <= Wr;
                  hiloWdata_q <= res_q;
                  cnt_q       <= 5'd0;
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            Div: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               if (cnt_q == DivLast) begin
                  state_q     <= Wr;
                  hiloWdata_q <= divRes;
                  cnt_q       <= 5'd0;
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            default: begin
               state_q <= Idle;
               cnt_q   <= 5'd0;
            end
         endcase
      end
   end

   assign busy       = (state_q != Idle);
   assign hilo_we    = (state_q == Wr) && !flush;
   assign hilo_wdata = hiloWdata_q;

endmodule

// File: doc/muldiv.md
Name: muldiv

Overview:
- Multi-cycle multiply/divide unit in the EX stage. It sits directly upstream of the HI/LO register and is its only writer.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, computes the 64-bit {hi, lo} result, and presents it to HI/LO as a one-cycle write pulse.
- Drives a busy flag that the pipeline uses to stall.

Parameters:
- MUL_LATENCY, 3, cycles from accept to the multiply write pulse; legal range 1..8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  operation request
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
- src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- src_b  in  32  rt operand (divisor / multiplier)
- flush  in  1  pipeline flush (exception/eret); aborts any operation
- hilo_rdata  in  64  current {hi, lo} from the HI/LO register
- busy  out  1  unit occupied; op_valid ignored while high
- hilo_we  out  1  HI/LO write-enable pulse
- hilo_wdata  out  64  {hi, lo} write data

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset (asserted at any time, including mid-operation):
  - state IDLE, iteration counter 0.
  - busy=0, hilo_we=0, hilo_wdata=0.
  - Partial results are discarded.
- Accept rule: accepted in cycle C0 when op_valid=1, busy=0, flush=0 and op is in 1..6. op 0 or 7 is ignored and leaves the unit in IDLE.
- States: IDLE, MUL, DIV, WR.
  - IDLE -> WR on MTHI/MTLO.
  - IDLE -> MUL on MULT/MULTU.
  - IDLE -> DIV on DIV/DIVU.
  - MUL -> WR after MUL_LATENCY-1 cycles; MUL_LATENCY=1 goes straight IDLE -> WR.
  - DIV -> WR after 32 iteration cycles.
  - WR -> IDLE.
- Operands are captured at C0. Later changes on src_a, src_b, op or hilo_rdata have no effect.
- busy=1 in every state except IDLE, i.e. from C1 through the WR cycle inclusive. Earliest next accept is the cycle after WR.
- Output timing:
  - hilo_we=1 only in the WR cycle; hilo_wdata is valid in that cycle and holds its last value otherwise.
  - MTHI/MTLO: WR = C1.
  - MULT/MULTU: WR = C(MUL_LATENCY).
  - DIV/DIVU: WR = C33.
- MTHI result: {src_a, hilo_rdata[31:0]}, with hilo_rdata sampled at C0.
- MTLO result: {hilo_rdata[63:32], src_a}, with hilo_rdata sampled at C0.
- MULTU: full 64-bit unsigned product.
- MULT: 64-bit two's-complement signed product.
- Multiplier may be implemented as a pipelined or iterative array; only the latency is fixed.
- DIVU: radix-2 restoring divide, one quotient bit per cycle over 32 cycles. hi = remainder, lo = quotient.
- DIV:
  - Divides operand magnitudes.
  - Quotient is negated when sign(a) xor sign(b).
  - Remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wrap, no trap).
- Divide by zero, DIV and DIVU alike: hi=src_a, lo=0xFFFFFFFF, with normal 33-cycle latency.
- flush:
  - Highest priority after reset.
  - In any state, flush=1 forces next state IDLE and discards the operation.
  - hilo_we is combinationally gated: hilo_we=0 in any cycle flush=1, including the WR cycle.
  - op_valid with flush in the same cycle is not accepted.
  - busy drops the cycle after flush.
- Simultaneous events:
  - op_valid while busy is ignored; no queuing.
  - The HI/LO register forwards written data in the WR cycle, so consumers see the result in that same cycle.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7, MUL_LATENCY=3 -> busy high C1..C3; hilo_we only at C3; hilo_wdata=0xFFFFFFFF_FFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hilo_wdata=0xFFFFFFFE_00000001. Back-to-back op_valid at C2 is ignored; same op re-issued at C4 is accepted.
- DIV a=0xFFFFFFF9 (-7), b=2 -> hilo_we at C33, hi=0xFFFFFFFF, lo=0xFFFFFFFD. DIV 0x80000000 / 0xFFFFFFFF -> hi=0, lo=0x80000000. DIVU 100/7 -> hi=2, lo=14.
- DIVU a=0x12345678, b=0 -> C33 hilo_wdata=0x12345678_FFFFFFFF.
- MTHI a=0xAAAA5555 with hilo_rdata=0x11112222_33334444 -> C1 hilo_we=1, hilo_wdata=0xAAAA5555_33334444, busy=1 at C1, busy=0 at C2. MTLO equivalently replaces the low word.
- Abort cases:
  - DIV with flush at C10 -> no hilo_we through C40; busy=0 from C11; new MULT accepted at C11.
  - Flush during a WR cycle -> hilo_we=0.
  - rst_n low at C20 of a divide -> all outputs 0 immediately; no write after release.
